// File: rtl/mem_port_pkg.sv
// mem_port_pkg: shared state encoding and address check for mem_port_master
package mem_port_pkg;
  typedef enum logic [2:0] {IDLE, WR, RD_ISSUE, RD_WAIT, ERR, FILL} state_e;
  function automatic logic addr_ok(input int unsigned addr, input int unsigned size);
    return addr < size;
  endfunction
endpackage

// File: rtl/mem_port_master.sv
// mem_port_master: valid/ready command front end and fill sequencer for a 1R/1W register-file memory
module mem_port_master
  import mem_port_pkg::*;
#(
  parameter int MEM_SIZE = 6,
  parameter int DATA_W = 10,
  localparam int ADDR_W = $clog2(MEM_SIZE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  input  logic              fill_start,
  input  logic [DATA_W-1:0] fill_value,
  output logic              fill_done,
  output logic              busy,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr_w,
  output logic [DATA_W-1:0] mem_data_in,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_addr_r,
  input  logic [DATA_W-1:0] mem_data_out
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MEM_SIZE - 1);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d, mem_addr_w_q, mem_addr_w_d, mem_addr_r_q, mem_addr_r_d;
  logic [DATA_W-1:0] fill_val_q, fill_val_d, mem_data_in_q, mem_data_in_d, rsp_data_q, rsp_data_d;
  logic mem_write_q, mem_write_d, mem_read_q, mem_read_d;
  logic rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d, fill_done_q, fill_done_d;
  assign cmd_ready = (state_q == IDLE) && !rsp_valid_q && !fill_start;
  assign busy = state_q != IDLE;
  assign mem_write = mem_write_q;
  assign mem_addr_w = mem_addr_w_q;
  assign mem_data_in = mem_data_in_q;
  assign mem_read = mem_read_q;
  assign mem_addr_r = mem_addr_r_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data = rsp_data_q;
  assign rsp_err = rsp_err_q;
  assign fill_done = fill_done_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    fill_val_d = fill_val_q;
    mem_write_d = 1'b0;
    mem_read_d = 1'b0;
    mem_addr_w_d = mem_addr_w_q;
    mem_data_in_d = mem_data_in_q;
    mem_addr_r_d = mem_addr_r_q;
    rsp_valid_d = rsp_valid_q && !rsp_ready;
    rsp_data_d = rsp_data_q;
    rsp_err_d = rsp_err_q;
    fill_done_d = 1'b0;
    case (state_q)
      IDLE:
        if (!rsp_valid_q && fill_start) begin
          state_d = FILL;
          cnt_d = '0;
          fill_val_d = fill_value;
          mem_write_d = 1'b1;
          mem_addr_w_d = '0;
          mem_data_in_d = fill_value;
        end else if (cmd_valid && cmd_ready) begin
          if (!addr_ok(32'(cmd_addr), MEM_SIZE)) state_d = ERR;
          else if (cmd_we) begin
            state_d = WR;
            mem_write_d = 1'b1;
            mem_addr_w_d = cmd_addr;
            mem_data_in_d = cmd_wdata;
          end else begin
            state_d = RD_ISSUE;
            mem_read_d = 1'b1;
            mem_addr_r_d = cmd_addr;
          end
        end
      WR, ERR, RD_WAIT: begin
        state_d = IDLE;
        rsp_valid_d = 1'b1;
        rsp_err_d = state_q == ERR;
        rsp_data_d = state_q == RD_WAIT ? mem_data_out : '0;
      end
      RD_ISSUE: state_d = RD_WAIT;
      FILL:
        if (cnt_q == LAST) begin
          state_d = IDLE;
          fill_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
          mem_write_d = 1'b1;
          mem_addr_w_d = cnt_q + 1'b1;
          mem_data_in_d = fill_val_q;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      fill_val_q <= '0;
      mem_write_q <= 1'b0;
      mem_read_q <= 1'b0;
      mem_addr_w_q <= '0;
      mem_data_in_q <= '0;
      mem_addr_r_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q <= 1'b0;
      fill_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      fill_val_q <= fill_val_d;
      mem_write_q <= mem_write_d;
      mem_read_q <= mem_read_d;
      mem_addr_w_q <= mem_addr_w_d;
      mem_data_in_q <= mem_data_in_d;
      mem_addr_r_q <= mem_addr_r_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q <= rsp_err_d;
      fill_done_q <= fill_done_d;
    end
endmodule

// File: tb/tb_mem_port_master.sv
// tb_mem_port_master: directed + random checks of mem_port_master against a behavioural register-file memory
module tb_mem_port_master;
  logic clk, rst, mem_clr;
  logic cmd_valid, cmd_ready, cmd_we;
  logic [2:0] cmd_addr;
  logic [9:0] cmd_wdata;
  logic rsp_valid, rsp_ready, rsp_err;
  logic [9:0] rsp_data;
  logic fill_start, fill_done, busy;
  logic [9:0] fill_value;
  logic mem_write, mem_read;
  logic [2:0] mem_addr_w, mem_addr_r;
  logic [9:0] mem_data_in, mem_data_out;
  logic [9:0] mem [6];
  logic [9:0] model [6];
  logic [10:0] rsp_q [$];
  int tests = 0, fails = 0, ready_mode = 1;

  mem_port_master #(.MEM_SIZE(6), .DATA_W(10)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .fill_start(fill_start), .fill_value(fill_value),
    .fill_done(fill_done), .busy(busy), .mem_write(mem_write), .mem_addr_w(mem_addr_w),
    .mem_data_in(mem_data_in), .mem_read(mem_read), .mem_addr_r(mem_addr_r), .mem_data_out(mem_data_out)
  );

  always_ff @(posedge clk or posedge mem_clr)
    if (mem_clr) begin
      for (int i = 0; i < 6; i++) mem[i] <= '0;
      mem_data_out <= '0;
    end else begin
      if (mem_write && int'(mem_addr_w) < 6) mem[mem_addr_w] <= mem_data_in;
      if (mem_read && int'(mem_addr_r) < 6) mem_data_out <= mem[mem_addr_r];
    end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      rsp_ready = ready_mode == 1 ? 1'b1 : ready_mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst && rsp_valid && rsp_ready) begin
      if (rsp_q.size() == 0) chk("rsp_unexpected", 1, 0);
      else begin
        logic [10:0] e;
        e = rsp_q.pop_front();
        chk("rsp_err", 32'(rsp_err), 32'(e[10]));
        chk("rsp_data", 32'(rsp_data), 32'(e[9:0]));
      end
    end
  end

  task automatic send(input logic we, input logic [2:0] a, input logic [9:0] d);
    int n;
    logic err;
    err = a >= 3'd6;
    cmd_valid = 1'b1;
    cmd_we = we;
    cmd_addr = a;
    cmd_wdata = d;
    n = 0;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      if (++n > 100) break;
    end
    if (n > 100) begin
      chk("accept_timeout", 1, 0);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    rsp_q.push_back({err, (err || we) ? 10'd0 : model[a]});
    if (!err && we) model[a] = d;
    #1;
    cmd_valid = 1'b0;
    if (err) chk("err_strobes_e0", {mem_write, mem_read}, 0);
    else if (we) chk("wr_strobe", {mem_write, mem_read, mem_addr_w, mem_data_in}, {2'b10, a, d});
    else chk("rd_strobe", {mem_write, mem_read, mem_addr_r}, {2'b01, a});
    @(posedge clk);
    #1;
    if (err) chk("err_strobes_e1", {mem_write, mem_read}, 0);
    if (err || we) chk("lat1_valid", 32'(rsp_valid), 1);
    else begin
      chk("rd_lat_e1", {rsp_valid, mem_read}, 0);
      @(posedge clk);
      #1;
      chk("rd_lat_e2", 32'(rsp_valid), 1);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    do @(negedge clk); while ((rsp_valid || busy) && ++n < 100);
    if (n >= 100) chk("idle_timeout", 1, 0);
  endtask

  initial begin
    rst = 1'b1;
    mem_clr = 1'b1;
    cmd_valid = 1'b0;
    cmd_we = 1'b0;
    cmd_addr = '0;
    cmd_wdata = '0;
    fill_start = 1'b0;
    fill_value = '0;
    for (int i = 0; i < 6; i++) model[i] = '0;
    #12;
    chk("reset_outs", {rsp_valid, rsp_data, rsp_err, fill_done, busy, mem_write, mem_addr_w,
                       mem_data_in, mem_read, mem_addr_r}, 0);
    chk("reset_cmd_ready", 32'(cmd_ready), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    mem_clr = 1'b0;
    send(1'b1, 3'd2, 10'h155);
    send(1'b0, 3'd2, 10'h000);
    send(1'b0, 3'd6, 10'h000);
    send(1'b1, 3'd7, 10'h3C3);
    send(1'b0, 3'd0, 10'h000);
    send(1'b1, 3'd1, 10'h3FF);
    wait_idle();
    @(posedge clk);
    #1;
    ready_mode = 0;
    send(1'b0, 3'd1, 10'h000);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", {rsp_valid, rsp_data, rsp_err, cmd_ready}, {1'b1, 10'h3FF, 1'b0, 1'b0});
      @(posedge clk);
      #1;
    end
    ready_mode = 1;
    @(posedge clk);
    #1;
    chk("bp_release", 32'(rsp_valid), 0);
    wait_idle();
    @(posedge clk);
    #1;
    fill_start = 1'b1;
    fill_value = 10'h2AA;
    cmd_valid = 1'b1;
    cmd_we = 1'b0;
    cmd_addr = 3'd0;
    @(negedge clk);
    chk("fill_prio_ready", 32'(cmd_ready), 0);
    @(posedge clk);
    #1;
    fill_start = 1'b0;
    cmd_valid = 1'b0;
    fill_value = 10'h001;
    for (int i = 0; i < 6; i++) begin
      chk("fill_write", {mem_write, mem_addr_w, mem_data_in, busy, cmd_ready, fill_done},
          {1'b1, 3'(i), 10'h2AA, 1'b1, 1'b0, 1'b0});
      @(posedge clk);
      #1;
    end
    chk("fill_done", {fill_done, mem_write, busy}, 3'b100);
    @(posedge clk);
    #1;
    chk("fill_done_pulse", 32'(fill_done), 0);
    for (int i = 0; i < 6; i++) model[i] = 10'h2AA;
    for (int i = 0; i < 6; i++) send(1'b0, 3'(i), 10'h000);
    wait_idle();
    @(posedge clk);
    #1;
    fill_start = 1'b1;
    fill_value = 10'h0F0;
    @(posedge clk);
    #1;
    fill_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    chk("rst_mid_fill", {rsp_valid, rsp_data, rsp_err, fill_done, busy, mem_write, mem_addr_w,
                         mem_data_in, mem_read, mem_addr_r}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_release", {busy, cmd_ready}, 2'b01);
    for (int i = 0; i < 3; i++) model[i] = 10'h0F0;
    for (int i = 0; i < 6; i++) send(1'b0, 3'(i), 10'h000);
    ready_mode = 2;
    for (int k = 0; k < 500; k++)
      send(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 10'($urandom_range(0, 1023)));
    ready_mode = 1;
    for (int n = 0; n < 100 && rsp_q.size() != 0; n++) @(negedge clk);
    chk("drain", 32'(rsp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mem_port_master.md
Name: mem_port_master

Overview:
- Initiator for the team's single-clock, 1-read/1-write register-file memory (registered read data, asynchronous clear to zero).
- Accepts valid/ready commands from a client and drives the memory's write and read strobes.
- Captures read data and returns exactly one response per command, with an out-of-range error flag.
- Provides a hardware fill sequence that writes a programmable value to every location.

Parameters:
MEM_SIZE, 6, number of memory words; must match the attached memory.
DATA_W, 10, data width in bits.
ADDR_W (localparam), $clog2(MEM_SIZE), address width.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
cmd_valid  in  1  command present.
cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at a rising edge.
cmd_we  in  1  1 = write, 0 = read.
cmd_addr  in  ADDR_W  target address.
cmd_wdata  in  DATA_W  write data.
rsp_valid  out  1  response present.
rsp_ready  in  1  client consumes the response.
rsp_data  out  DATA_W  read data; 0 for writes and errors.
rsp_err  out  1  address was >= MEM_SIZE.
fill_start  in  1  request a fill sequence.
fill_value  in  DATA_W  fill data, sampled at fill acceptance.
fill_done  out  1  single-cycle pulse when the fill completes.
busy  out  1  FSM is not in IDLE.
mem_write  out  1  memory write strobe.
mem_addr_w  out  ADDR_W  memory write address.
mem_data_in  out  DATA_W  memory write data.
mem_read  out  1  memory read strobe.
mem_addr_r  out  ADDR_W  memory read address.
mem_data_out  in  DATA_W  memory registered read data, valid the cycle after mem_read.

Behaviour:
- Reset (async, any state):
  - State returns to IDLE. All outputs, the fill counter and the captured fill value clear to 0.
  - Any in-flight command or response is dropped. Memory contents are not touched by this block.
- FSM states: IDLE, WR, RD_ISSUE, RD_WAIT, ERR, FILL. All memory-side outputs are registered.
- cmd_ready = (state == IDLE) && !rsp_valid && !fill_start. Only one command is outstanding at a time.
- fill_start has priority over cmd_valid in the same cycle. fill_start is ignored when not in IDLE or while rsp_valid = 1.
- Acceptance, edge E0, out-of-range (cmd_addr >= MEM_SIZE):
  - Go to ERR; no memory strobe is issued.
  - At E1: rsp_valid = 1, rsp_err = 1, rsp_data = 0; return to IDLE.
- Acceptance at E0, write in range:
  - Go to WR with mem_write = 1, mem_addr_w = cmd_addr, mem_data_in = cmd_wdata for exactly one cycle.
  - At E1 the memory writes; rsp_valid = 1, rsp_err = 0, rsp_data = 0; return to IDLE.
- Acceptance at E0, read in range:
  - Go to RD_ISSUE with mem_read = 1, mem_addr_r = cmd_addr for one cycle.
  - At E1: RD_WAIT, mem_read = 0.
  - At E2: rsp_data <= mem_data_out, rsp_valid = 1; return to IDLE.
  - Read latency is 2 cycles from the acceptance edge to rsp_valid.
- Response hold:
  - rsp_valid, rsp_data and rsp_err hold stable until an edge with rsp_ready = 1.
  - At that edge rsp_valid clears; rsp_data and rsp_err keep their last value.
  - The next command is accepted no earlier than the following edge.
- FILL:
  - Acceptance at E0 captures fill_value and sets the counter to 0.
  - Each FILL cycle drives mem_write = 1, mem_addr_w = counter, mem_data_in = captured value, then increments the counter.
  - After the write to address MEM_SIZE-1, return to IDLE; fill_done pulses for 1 cycle, aligned with the first IDLE cycle.
  - A fill takes MEM_SIZE cycles with mem_write = 1. busy = 1 throughout; cmd_ready = 0 throughout.
- mem_write and mem_read are never asserted in the same cycle.
- The counter never wraps past MEM_SIZE-1, including when MEM_SIZE is a power of 2 (compare before increment).

Decomposition:
- Package mem_port_pkg:
  - state enum typedef.
  - a function for the address-in-range check (addr < MEM_SIZE).
- No sub-module needed. The FSM, fill counter and response register stay in one module.
- The bench instantiates the memory block alongside this master.

Test Plan:
- Write then read: write addr 2 with data 0x155, then read addr 2 -> write response err = 0 after 1 cycle; read rsp_data = 0x155 with rsp_valid exactly 2 cycles after acceptance.
- Out of range: read addr 6, then write addr 7 (MEM_SIZE = 6) -> rsp_err = 1, rsp_data = 0, no mem_read/mem_write pulses; a following read of addr 0 returns 0.
- Backpressure: hold rsp_ready = 0 for 5 cycles after a read of addr 1 holding 0x3FF -> rsp_valid and rsp_data stay stable, cmd_ready = 0 throughout; the handshake clears rsp_valid.
- Fill: fill_start with fill_value 0x2AA, asserted together with cmd_valid -> fill wins; 6 consecutive write cycles at addr 0..5; fill_done single pulse; reads of addr 0..5 all return 0x2AA.
- Reset mid-operation: assert rst during FILL after 3 writes -> all outputs 0 immediately; after release busy = 0, cmd_ready = 1; addr 3..5 unchanged by the aborted fill.
- Random: 500 random commands with random rsp_ready, checked against a scoreboard model -> one response per command, in order, with no mismatches.
